pic_nch: RTL and testbench
==========================

// Module: pic_nch
// PURPOSE
//  Parametrised 8259-subset interrupt controller with NUM_IRQ request lines.
//  Replaces the fixed two-input PIC beside the V20 bus bridge; sits on the
//  internal CPU bus.
//  Implements: edge-triggered IRR, an IMR and ISR, fixed priority, EOI, an ICW
//  init sequence, the IRR/ISR read-back, and the two-cycle INTA vector protocol.
// PARAMETERS
//  NUM_IRQ        8        request lines, 1..8; bit 0 is the highest priority
//  BASE_ADDR      16'h0020 I/O base; BASE = command, BASE+1 = data/IMR
//  SYNC_STAGES    2        synchroniser flops per iIrq line, >=2
//  DEFAULT_VECTOR 8'h08    vector base after reset; bits [2:0] are ignored
// PORTS
//  iClk     in  1        system clock, the 10 MHz bus clock
//  iRstN    in  1        asynchronous active-low reset
//  iAddr    in  20       CPU address; only [15:0] is decoded
//  iData    in  8        CPU write data
//  iWr      in  1        I/O write strobe, single-cycle pulse
//  iRd      in  1        I/O read strobe
//  iIrq     in  NUM_IRQ  asynchronous request lines, active high
//  iIntAck  in  1        INTA bus cycle, high for the whole cycle
//  oInt     out 1        interrupt request to the CPU, registered
//  oSel     out 1        drives oData onto the bus read mux (combinational)
//  oData    out 8        read data / vector (combinational)
// BEHAVIOUR
//  Reset:
//  - oInt=0, IRR=0, ISR=0, IMR=0, vector base=DEFAULT_VECTOR.
//  - Read select = IRR, init FSM=IDLE, INTA phase=0.
//  Request path and priority:
//  - Each iIrq passes SYNC_STAGES flops, then a registered rising-edge detect.
//    A detected edge sets IRR[n].
//  - Unused bits of the 8-bit registers read as 0 and never request.
//  - Candidate = lowest n with IRR[n] & ~IMR[n].
//  - oInt is registered: next cycle it is 1 iff a candidate exists and
//    n < the lowest set ISR bit (or ISR=0).
//  - Latency from an iIrq rise, first sampled, to oInt=1 is SYNC_STAGES+2 clocks.
//  Address decode:
//  - hit = iAddr[15:1]==BASE_ADDR[15:1].
//  - oSel = (iRd & hit) | iIntAck.
//  - oData on iRd: iAddr[0]=0 returns IRR or ISR (per read select);
//    iAddr[0]=1 returns IMR.
//  Writes to BASE (iAddr[0]=0):
//  - iData[4]=1 is ICW1: IMR=0, ISR=0, IRR=0, INTA phase=0, FSM->ICW2.
//    ICW1 iData[0] is latched as "ICW4 expected".
//  - iData[4:3]=00 is OCW2:
//    - 0x20: non-specific EOI, clears the lowest set ISR bit.
//    - 0x60|n: specific EOI, clears ISR[n]; n >= NUM_IRQ is ignored.
//    - Other OCW2 codes are ignored.
//  - iData[4:3]=01 is OCW3: if iData[1]=1, read select = iData[0]
//    (0 = IRR, 1 = ISR).
//  Init FSM, writes to BASE+1:
//  - IDLE: the write loads IMR.
//  - ICW2: vector base=iData&8'hF8. Go to ICW4 if ICW4 expected, else IDLE.
//  - ICW4: the data is consumed and ignored; go to IDLE.
//  - A write to BASE while in ICW2 or ICW4 aborts to IDLE, then decodes normally.
//  INTA protocol:
//  - Action happens on the first clock of each INTA cycle (rising edge of
//    iIntAck); the INTA phase toggles each cycle.
//  - Phase 0 (INTA1), candidate valid: freeze n, set ISR[n], clear IRR[n].
//    oData=8'hFF.
//  - Phase 0, no candidate: spurious. Freeze n=7 and leave ISR unchanged.
//  - Phase 1 (INTA2): oData = vector base | frozen n, for the whole cycle.
//  - oInt drops in the cycle after INTA1. It may re-assert after INTA2 if a
//    higher-priority request is pending.
//  Simultaneous events:
//  - New edge and INTA1 clear on the same bit in the same cycle: IRR stays set.
//  - EOI and INTA1 in the same cycle: the EOI clear applies first, then the
//    INTA1 set.
//  - An IMR write takes effect on oInt in the next cycle. A frozen INTA n is
//    unaffected.
//  - iRstN low mid-INTA or mid-init returns everything to reset values at once.
// TESTING
//  1. Reset, pulse iIrq[0] -> oInt=1 after SYNC_STAGES+2 clks.
//     Then INTA,INTA -> 0xFF then 0x08, and ISR=0x01.
//  2. IRQ3 and IRQ1 rise together -> first vector 0x09.
//     After EOI 0x20 -> second vector 0x0B.
//  3. Write IMR=0x02, then raise IRQ1 -> oInt stays 0.
//     Write IMR=0x00 -> oInt=1 next-but-one clk.
//  4. ICW1=0x11, ICW2=0x70, ICW4=0x01, then IRQ2 -> vector 0x72.
//     Read BASE+1 -> 0x00.
//  5. ISR[1] set and IRQ4 pending -> oInt=0. Specific EOI 0x61 -> oInt=1.
//     OCW3 0x0B then read BASE -> ISR value.
//  6. Raise IRQ5, mask it (IMR=0x20) before INTA -> spurious vector 0x0F.
//     ISR unchanged. Assert iRstN=0 mid-INTA -> all registers reset.

Source files
------------

// File: rtl/pic_nch.sv
// 8259-subset interrupt controller: edge-triggered IRR, IMR/ISR, fixed priority,
// EOI, ICW init sequence and the two-cycle INTA vector protocol.
module pic_nch #(
    parameter int          NUM_IRQ        = 8,
    parameter logic [15:0] BASE_ADDR      = 16'h0020,
    parameter int          SYNC_STAGES    = 2,
    parameter logic [7:0]  DEFAULT_VECTOR = 8'h08
) (
    input  logic               iClk,
    input  logic               iRstN,
    input  logic [19:0]        iAddr,
    input  logic [7:0]         iData,
    input  logic               iWr,
    input  logic               iRd,
    input  logic [NUM_IRQ-1:0] iIrq,
    input  logic               iIntAck,
    output logic               oInt,
    output logic               oSel,
    output logic [7:0]         oData
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ICW2 = 2'd1;
    localparam logic [1:0] ST_ICW4 = 2'd2;

    localparam logic [7:0] VALID_MASK = 8'((9'd1 << NUM_IRQ) - 9'd1);

    logic [7:0] irr_reg, irr_next;
    logic [7:0] isr_reg, isr_next;
    logic [7:0] imr_reg, imr_next;
    logic [7:0] vec_reg, vec_next;
    logic [2:0] frozen_reg, frozen_next;
    logic [1:0] state_reg, state_next;
    logic       icw4_exp_reg, icw4_exp_next;
    logic       rsel_reg, rsel_next;
    logic       phase_reg, phase_next;
    logic       inta_prev_reg;
    logic       int_reg, int_next;

    logic [NUM_IRQ-1:0] edge_det;
    logic [7:0]         edge8;

    // Per-line synchroniser followed by a registered previous value for edge detection
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            logic                   prev_reg;
            always_ff @(posedge iClk or negedge iRstN) begin
                if (!iRstN) begin
                    chain_reg <= '0;
                    prev_reg  <= 1'b0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], iIrq[gi]};
                    prev_reg  <= chain_reg[SYNC_STAGES-1];
                end
            end
            assign edge_det[gi] = chain_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    endgenerate

    always_comb begin
        edge8                = '0;
        edge8[NUM_IRQ-1:0]   = edge_det;
    end

    logic       hit;
    logic       addr_unused;
    logic       wr_cmd, wr_data;
    logic       icw1, ocw2, ocw3, ns_eoi, sp_eoi;
    logic       inta_rise, inta1, cur_phase;
    logic [7:0] pending;
    logic       cand_valid;
    logic [2:0] cand_n;
    logic [3:0] isr_low_n;

    assign hit         = (iAddr[15:1] == BASE_ADDR[15:1]);
    assign addr_unused = ^iAddr[19:16];
    assign wr_cmd      = iWr & hit & ~iAddr[0];
    assign wr_data     = iWr & hit & iAddr[0];
    assign icw1        = wr_cmd & iData[4];
    assign ocw2        = wr_cmd & (iData[4:3] == 2'b00);
    assign ocw3        = wr_cmd & (iData[4:3] == 2'b01);
    assign ns_eoi      = ocw2 & (iData == 8'h20);
    assign sp_eoi      = ocw2 & (iData[7:3] == 5'b01100);
    assign inta_rise   = iIntAck & ~inta_prev_reg;
    assign inta1       = inta_rise & ~phase_reg;
    // Phase register toggles on the first INTA clock; hold the pre-toggle view for the whole cycle
    assign cur_phase   = inta_rise ? phase_reg : ~phase_reg;
    assign pending     = irr_reg & ~imr_reg;

    always_comb begin
        cand_valid = 1'b0;
        cand_n     = 3'd0;
        isr_low_n  = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) begin
                cand_valid = 1'b1;
                cand_n     = 3'(i);
            end
            if (isr_reg[i]) begin
                isr_low_n = 4'(i);
            end
        end
    end

    assign int_next = cand_valid && ({1'b0, cand_n} < isr_low_n);

    always_comb begin
        irr_next      = irr_reg;
        isr_next      = isr_reg;
        imr_next      = imr_reg;
        vec_next      = vec_reg;
        frozen_next   = frozen_reg;
        state_next    = state_reg;
        icw4_exp_next = icw4_exp_reg;
        rsel_next     = rsel_reg;
        phase_next    = phase_reg;

        if (icw1) begin
            irr_next      = '0;
            isr_next      = '0;
            imr_next      = '0;
            phase_next    = 1'b0;
            state_next    = ST_ICW2;
            icw4_exp_next = iData[0];
        end else begin
            if (inta1 && cand_valid) begin
                irr_next[cand_n] = 1'b0;
            end
            // EOI clears before the INTA1 set so a same-cycle acknowledge survives
            if (ns_eoi && !isr_low_n[3]) begin
                isr_next[isr_low_n[2:0]] = 1'b0;
            end
            if (sp_eoi) begin
                isr_next[iData[2:0]] = 1'b0;
            end
            if (inta1 && cand_valid) begin
                isr_next[cand_n] = 1'b1;
            end
            if (inta_rise) begin
                phase_next = ~phase_reg;
            end
            if (wr_cmd) begin
                state_next = ST_IDLE;
            end
        end

        irr_next = (irr_next | edge8) & VALID_MASK;
        isr_next = isr_next & VALID_MASK;

        if (inta1) begin
            frozen_next = cand_valid ? cand_n : 3'd7;
        end

        if (ocw3 && iData[1]) begin
            rsel_next = iData[0];
        end

        if (wr_data) begin
            case (state_reg)
                ST_IDLE: imr_next = iData & VALID_MASK;
                ST_ICW2: begin
                    vec_next   = iData & 8'hF8;
                    state_next = icw4_exp_reg ? ST_ICW4 : ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            irr_reg       <= '0;
            isr_reg       <= '0;
            imr_reg       <= '0;
            vec_reg       <= DEFAULT_VECTOR & 8'hF8;
            frozen_reg    <= '0;
            state_reg     <= ST_IDLE;
            icw4_exp_reg  <= 1'b0;
            rsel_reg      <= 1'b0;
            phase_reg     <= 1'b0;
            inta_prev_reg <= 1'b0;
            int_reg       <= 1'b0;
        end else begin
            irr_reg       <= irr_next;
            isr_reg       <= isr_next;
            imr_reg       <= imr_next;
            vec_reg       <= vec_next;
            frozen_reg    <= frozen_next;
            state_reg     <= state_next;
            icw4_exp_reg  <= icw4_exp_next;
            rsel_reg      <= rsel_next;
            phase_reg     <= phase_next;
            inta_prev_reg <= iIntAck;
            int_reg       <= int_next;
        end
    end

    assign oInt = int_reg;
    assign oSel = (iRd & hit) | iIntAck;

    always_comb begin
        oData = 8'h00;
        if (iIntAck) begin
            oData = cur_phase ? (vec_reg | {5'd0, frozen_reg}) : 8'hFF;
        end else if (iRd && hit) begin
            if (iAddr[0]) begin
                oData = imr_reg;
            end else begin
                oData = rsel_reg ? isr_reg : irr_reg;
            end
        end
    end

endmodule

// File: tb/tb_pic_nch.sv
// Directed bench for pic_nch: request latency, priority, masking, init sequence,
// EOI variants, spurious INTA and reset during an INTA cycle.
module tb_pic_nch;

    localparam logic [15:0] BASE  = 16'h0020;
    localparam logic [15:0] BASE1 = 16'h0021;

    logic        clk;
    logic        rst_n;
    logic [19:0] addr;
    logic [7:0]  cpu_data;
    logic        wr;
    logic        rd;
    logic [7:0]  irq;
    logic        int_ack;
    logic        int_req;
    logic        sel;
    logic [7:0]  rd_data;

    int n_checks = 0;
    int n_errors = 0;

    pic_nch #(
        .NUM_IRQ        (8),
        .BASE_ADDR      (16'h0020),
        .SYNC_STAGES    (2),
        .DEFAULT_VECTOR (8'h08)
    ) dut (
        .iClk    (clk),
        .iRstN   (rst_n),
        .iAddr   (addr),
        .iData   (cpu_data),
        .iWr     (wr),
        .iRd     (rd),
        .iIrq    (irq),
        .iIntAck (int_ack),
        .oInt    (int_req),
        .oSel    (sel),
        .oData   (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input logic exp);
        check_value(tag, {7'd0, int_req}, {7'd0, exp});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        addr     = {4'h0, a};
        cpu_data = d;
        wr       = 1'b1;
        tick(1);
        wr       = 1'b0;
        $display("WR  %04h <= %02h", a, d);
    endtask

    task automatic io_read(input logic [15:0] a, input logic [7:0] exp, input string tag);
        addr = {4'h0, a};
        rd   = 1'b1;
        #1;
        check_value(tag, rd_data, exp);
        check_value({tag, "_sel"}, {7'd0, sel}, 8'd1);
        $display("RD  %04h -> %02h (%s)", a, rd_data, tag);
        rd   = 1'b0;
    endtask

    // One INTA bus cycle held for the action clock; data must be stable across it
    task automatic inta(input logic [7:0] exp, input string tag);
        logic [7:0] first;
        int_ack = 1'b1;
        #1;
        first = rd_data;
        check_value({tag, "_pre"}, first, exp);
        tick(1);
        check_value(tag, rd_data, exp);
        check_value({tag, "_sel"}, {7'd0, sel}, 8'd1);
        $display("ACK data %02h (%s)", first, tag);
        int_ack = 1'b0;
        tick(1);
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; cpu_data = '0; wr = 1'b0; rd = 1'b0;
        irq = '0; int_ack = 1'b0;
        tick(3);
        check_int("rst_int", 1'b0);
        rst_n = 1'b1;
        tick(1);
        io_read(BASE, 8'h00, "rst_irr");
        io_read(BASE1, 8'h00, "rst_imr");

        // 1: single request latency, INTA pair, ISR read-back
        irq[0] = 1'b1;
        tick(3);
        check_int("t1_lat_early", 1'b0);
        tick(1);
        check_int("t1_lat", 1'b1);
        irq[0] = 1'b0;
        inta(8'hFF, "t1_inta1");
        check_int("t1_int_drop", 1'b0);
        inta(8'h08, "t1_vec");
        io_write(BASE, 8'h0B);
        io_read(BASE, 8'h01, "t1_isr");
        io_write(BASE, 8'h20);
        io_read(BASE, 8'h00, "t1_isr_eoi");
        io_write(BASE, 8'h0A);
        addr = 20'h00030;
        rd   = 1'b1;
        #1;
        check_value("t1_miss_sel", {7'd0, sel}, 8'd0);
        rd   = 1'b0;

        // 2: simultaneous IRQ3/IRQ1, priority, non-specific EOI
        irq = 8'h0A;
        tick(5);
        check_int("t2_int", 1'b1);
        inta(8'hFF, "t2_inta1");
        inta(8'h09, "t2_vec1");
        check_int("t2_isr_block", 1'b0);
        io_read(BASE, 8'h08, "t2_irr");
        io_write(BASE, 8'h20);
        tick(1);
        check_int("t2_int2", 1'b1);
        inta(8'hFF, "t2_inta1b");
        inta(8'h0B, "t2_vec2");
        io_write(BASE, 8'h20);
        irq = '0;
        tick(3);

        // 3: masking and unmask latency
        io_write(BASE1, 8'h02);
        irq[1] = 1'b1;
        tick(6);
        check_int("t3_masked", 1'b0);
        io_read(BASE1, 8'h02, "t3_imr");
        io_read(BASE, 8'h02, "t3_irr");
        io_write(BASE1, 8'h00);
        check_int("t3_unmask_next", 1'b0);
        tick(1);
        check_int("t3_unmask", 1'b1);
        inta(8'hFF, "t3_inta1");
        inta(8'h09, "t3_vec");
        io_write(BASE, 8'h20);
        irq = '0;
        tick(3);

        // 4: full init sequence with ICW4
        io_write(BASE, 8'h11);
        io_write(BASE1, 8'h70);
        io_write(BASE1, 8'h01);
        io_read(BASE1, 8'h00, "t4_imr");
        irq[2] = 1'b1;
        tick(5);
        check_int("t4_int", 1'b1);
        inta(8'hFF, "t4_inta1");
        inta(8'h72, "t4_vec");
        io_write(BASE, 8'h20);
        irq = '0;
        tick(3);

        // 5: in-service blocks lower priority; specific EOI
        irq[1] = 1'b1;
        tick(5);
        inta(8'hFF, "t5_inta1");
        inta(8'h71, "t5_vec1");
        irq[4] = 1'b1;
        tick(5);
        check_int("t5_isr_block", 1'b0);
        io_write(BASE, 8'h0B);
        io_read(BASE, 8'h02, "t5_isr");
        io_write(BASE, 8'h61);
        io_read(BASE, 8'h00, "t5_isr_eoi");
        tick(1);
        check_int("t5_int", 1'b1);
        io_write(BASE, 8'h0A);
        io_read(BASE, 8'h10, "t5_irr");
        inta(8'hFF, "t5_inta1b");
        inta(8'h74, "t5_vec2");
        io_write(BASE, 8'h64);
        irq = '0;
        tick(3);

        // 6: init without ICW4, mask before INTA -> spurious, then reset mid-INTA
        io_write(BASE, 8'h10);
        io_write(BASE1, 8'h08);
        irq[5] = 1'b1;
        tick(5);
        check_int("t6_int", 1'b1);
        io_write(BASE1, 8'h20);
        tick(1);
        check_int("t6_masked", 1'b0);
        io_read(BASE1, 8'h20, "t6_imr");
        inta(8'hFF, "t6_inta1");
        inta(8'h0F, "t6_spurious");
        io_write(BASE, 8'h0B);
        io_read(BASE, 8'h00, "t6_isr");
        io_write(BASE, 8'h0A);
        io_read(BASE, 8'h20, "t6_irr");
        irq = '0;
        tick(3);
        int_ack = 1'b1;
        tick(1);
        rst_n = 1'b0;
        #1;
        int_ack = 1'b0;
        check_int("t6_rst_int", 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        io_read(BASE, 8'h00, "t6_rst_irr");
        io_read(BASE1, 8'h00, "t6_rst_imr");
        irq[0] = 1'b1;
        tick(5);
        check_int("t6_rst_req", 1'b1);
        inta(8'hFF, "t6_rst_phase");
        inta(8'h08, "t6_rst_vec");
        irq = '0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
